// File: rtl/i2s_audio_receiver.sv
// i2s_audio_receiver
//
// Recovers DATA_WIDTH-bit left/right PCM words from an I2S stream that is
// asynchronous to clk. sck/lrck/sdin are brought into the clk domain by
// 2-flop synchronisers, and sck is oversampled to find its rising edges.
// All serial sampling happens on those edges.
//
// Ports:
//   clk          system clock, at least 4x audio_sck
//   rst          synchronous active-high reset
//   audio_sck    I2S bit clock (async)
//   audio_lrck   I2S word select (async), 0 = left, 1 = right
//   audio_sdin   I2S serial data (async), MSB first, changes on sck fall
//   audio_left   last complete left word
//   audio_right  last complete right word
//   sample_valid 1-cycle pulse, new L/R pair on the outputs
//   frame_err    1-cycle pulse, a slot ended with fewer than DATA_WIDTH bits
//   locked       high after the first complete L/R frame since reset/error

module i2s_audio_receiver #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  audio_sck,
    input  logic                  audio_lrck,
    input  logic                  audio_sdin,
    output logic [DATA_WIDTH-1:0] audio_left,
    output logic [DATA_WIDTH-1:0] audio_right,
    output logic                  sample_valid,
    output logic                  frame_err,
    output logic                  locked
);

    localparam int unsigned     CntW    = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DATA_WIDTH);

    localparam logic [1:0] StAlign = 2'd0;
    localparam logic [1:0] StLeft  = 2'd1;
    localparam logic [1:0] StRight = 2'd2;

    // Synchronisers; sck_s3 is the edge-detect register.
    logic sck_s1, sck_s2, sck_s3;
    logic lrck_s1, lrck_s2;
    logic sdin_s1, sdin_s2;

    logic                  ws_primed;
    logic                  ws_prev;
    logic                  channel;
    logic [CntW-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  word_done;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] left_hold;
    logic                  left_ok;

    logic sck_rise;
    logic ws;
    logic sd;
    logic boundary;
    logic shift_en;
    logic short_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_s3  <= 1'b0;
            lrck_s1 <= 1'b0;
            lrck_s2 <= 1'b0;
            sdin_s1 <= 1'b0;
            sdin_s2 <= 1'b0;
        end else begin
            sck_s1  <= audio_sck;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            lrck_s1 <= audio_lrck;
            lrck_s2 <= lrck_s1;
            sdin_s1 <= audio_sdin;
            sdin_s2 <= sdin_s1;
        end
    end

    always_comb begin
        sck_rise   = sck_s2 & ~sck_s3;
        ws         = lrck_s2;
        sd         = sdin_s2;
        // ws_prev only means something once a real lrck level has been seen;
        // before that the reset value 0 would fake a boundary when joining a
        // right slot, so alignment waits for a genuine lrck edge.
        boundary   = sck_rise & ws_primed & (ws != ws_prev);
        shift_en   = sck_rise & ws_primed & ~boundary & (state != StAlign) &
                     (bit_cnt < CntFull);
        short_slot = boundary & (state != StAlign) & (bit_cnt < CntFull);
    end

    // Slot tracking and bit capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ws_primed <= 1'b0;
            ws_prev   <= 1'b0;
            channel   <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (sck_rise && !ws_primed) begin
                ws_primed <= 1'b1;
                ws_prev   <= ws;
            end
            if (boundary) begin
                // The boundary bit is the I2S delay bit and is dropped.
                ws_prev <= ws;
                channel <= ws;
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (shift_en) begin
                shreg   <= {shreg[DATA_WIDTH-2:0], sd};
                bit_cnt <= bit_cnt + CntW'(1);
                // Bits past DATA_WIDTH are ignored, so longer slots keep
                // their top DATA_WIDTH bits.
                if (bit_cnt == CntFull - CntW'(1)) begin
                    word_done <= 1'b1;
                end
            end
        end
    end

    // Channel FSM and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StAlign;
            left_hold    <= '0;
            left_ok      <= 1'b0;
            audio_left   <= '0;
            audio_right  <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            locked       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;

            // word_done and a boundary can never share a cycle: two sck
            // rises are always at least two clk apart.
            if (word_done) begin
                case (state)
                    StLeft: begin
                        if (!channel) begin
                            left_hold <= shreg;
                            left_ok   <= 1'b1;
                        end
                    end
                    StRight: begin
                        if (channel) begin
                            // Only a right word that completes a left word
                            // publishes a pair.
                            if (left_ok) begin
                                audio_left   <= left_hold;
                                audio_right  <= shreg;
                                sample_valid <= 1'b1;
                                locked       <= 1'b1;
                            end
                            left_ok <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end

            if (boundary) begin
                state <= ws ? StRight : StLeft;
                // The slot ending in ALIGN is a partial join and is never an
                // error; a short slot otherwise drops the pair in progress.
                if (short_slot) begin
                    frame_err <= 1'b1;
                    left_ok   <= 1'b0;
                    locked    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_audio_receiver.sv
// Self-checking bench for i2s_audio_receiver. A slot-level model predicts
// which L/R pairs and how many frame errors the stream must produce; a
// per-cycle compare process checks the DUT outputs against it.

module tb_i2s_audio_receiver;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic audio_sck = 1'b0;
    logic audio_lrck = 1'b1;
    logic audio_sdin = 1'b0;
    logic [DW-1:0] audio_left;
    logic [DW-1:0] audio_right;
    logic sample_valid;
    logic frame_err;
    logic locked;

    i2s_audio_receiver #(
        .DATA_WIDTH(DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .audio_sck   (audio_sck),
        .audio_lrck  (audio_lrck),
        .audio_sdin  (audio_sdin),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .sample_valid(sample_valid),
        .frame_err   (frame_err),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    int half = 4;
    int last_rise_cyc = 0;
    int last_valid_cyc = 0;
    int n_valid = 0;
    int n_err = 0;

    // Slot-level model of the receiver.
    logic [31:0] exp_q[$];
    int          exp_valid = 0;
    int          exp_err = 0;
    logic        m_seen = 1'b0;
    logic        m_last_c = 1'b0;
    logic        m_aligned = 1'b0;
    int          m_prev_n = 0;
    logic        m_left_ok = 1'b0;
    logic [15:0] m_left_val = '0;

    logic [15:0] cur_l = '0;
    logic [15:0] cur_r = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare process: one sample per clk, #1 after the active edge.
    initial begin
        logic [31:0] pair;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                cur_l = '0;
                cur_r = '0;
                check("reset_left", {16'b0, audio_left}, 32'd0);
                check("reset_right", {16'b0, audio_right}, 32'd0);
                check("reset_valid", {31'b0, sample_valid}, 32'd0);
                check("reset_err", {31'b0, frame_err}, 32'd0);
                check("reset_locked", {31'b0, locked}, 32'd0);
            end else begin
                if (sample_valid || frame_err)
                    check("pulse_overlap", {31'b0, sample_valid & frame_err}, 32'd0);
                if (sample_valid) begin
                    n_valid++;
                    last_valid_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_valid: got L=%0h R=%0h, expected no pulse",
                                 audio_left, audio_right);
                    end else begin
                        pair  = exp_q.pop_front();
                        cur_l = pair[31:16];
                        cur_r = pair[15:0];
                    end
                    check("valid_locked", {31'b0, locked}, 32'd1);
                end
                if (frame_err) n_err++;
                check("left_out", {16'b0, audio_left}, {16'b0, cur_l});
                check("right_out", {16'b0, audio_right}, {16'b0, cur_r});
            end
        end
    end

    // One lrck slot: a delay bit then slot_len-1 data bits (low bits of data,
    // MSB first). rst_at >= 0 releases a held reset, or pulses reset for one
    // clk, at the start of that bit.
    task automatic send_slot(input logic c, input int slot_len, input logic [31:0] data,
                             input int rst_at);
        int          n;
        logic [15:0] top;
        logic        bnd;
        n   = slot_len - 1;
        bnd = m_seen && (c != m_last_c);
        if (bnd) begin
            if (m_aligned && m_prev_n < DW) begin
                exp_err++;
                m_left_ok = 1'b0;
            end
            m_aligned = 1'b1;
        end
        if (rst_at >= 0) begin
            m_aligned = 1'b0;
            m_left_ok = 1'b0;
        end else if (m_aligned && n >= DW) begin
            top = 16'(data >> (n - DW));
            if (!c) begin
                m_left_ok  = 1'b1;
                m_left_val = top;
            end else begin
                if (m_left_ok) begin
                    exp_q.push_back({m_left_val, top});
                    exp_valid++;
                end
                m_left_ok = 1'b0;
            end
        end
        m_prev_n = n;
        m_last_c = c;
        m_seen   = 1'b1;

        for (int i = 0; i < slot_len; i++) begin
            if (i == rst_at) begin
                if (rst) begin
                    rst = 1'b0;
                end else begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    check("rstpulse_left", {16'b0, audio_left}, 32'd0);
                    check("rstpulse_right", {16'b0, audio_right}, 32'd0);
                    check("rstpulse_locked", {31'b0, locked}, 32'd0);
                    check("rstpulse_valid", {31'b0, sample_valid}, 32'd0);
                end
            end
            audio_sck  = 1'b0;
            audio_lrck = c;
            audio_sdin = (i == 0) ? 1'b1 : data[n-i];
            wait_clks(half);
            audio_sck     = 1'b1;
            last_rise_cyc = cyc;
            wait_clks(half);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, DW + 1, {16'b0, l}, -1);
        send_slot(1'b1, DW + 1, {16'b0, r}, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] l;
        logic [15:0] r;
        wait_clks(5);

        // Join mid-frame: reset released partway through a right slot.
        half = 4;
        send_slot(1'b1, DW + 1, {16'b0, 16'h5A5A}, 6);
        check("join_no_valid", 32'(n_valid), 32'd0);
        send_frame(16'hA5C3, 16'h0F0F);
        wait_clks(8);
        check("nom1_left", {16'b0, audio_left}, 32'h0000_A5C3);
        check("nom1_right", {16'b0, audio_right}, 32'h0000_0F0F);
        check("nom1_locked", {31'b0, locked}, 32'd1);
        check("nom1_count", 32'(n_valid), 32'd1);
        check("nom1_latency", 32'(last_valid_cyc - last_rise_cyc), 32'd4);
        check("join_no_err", 32'(n_err), 32'd0);

        send_frame(16'h8000, 16'h7FFF);
        wait_clks(8);
        check("nom2_left", {16'b0, audio_left}, 32'h0000_8000);
        check("nom2_right", {16'b0, audio_right}, 32'h0000_7FFF);
        check("nom2_count", 32'(n_valid), 32'd2);

        // Short left slot (10 data bits), then a normal right slot.
        send_slot(1'b0, 11, {22'b0, 10'h2AA}, -1);
        send_slot(1'b1, DW + 1, {16'b0, 16'h1234}, -1);
        wait_clks(8);
        check("short_err", 32'(n_err), 32'd1);
        check("short_locked", {31'b0, locked}, 32'd0);
        check("short_count", 32'(n_valid), 32'd2);
        check("short_hold_l", {16'b0, audio_left}, 32'h0000_8000);
        check("short_hold_r", {16'b0, audio_right}, 32'h0000_7FFF);
        send_frame(16'hC001, 16'h0ACE);
        wait_clks(8);
        check("relock_locked", {31'b0, locked}, 32'd1);
        check("relock_left", {16'b0, audio_left}, 32'h0000_C001);
        check("relock_right", {16'b0, audio_right}, 32'h0000_0ACE);

        // 24-bit slots keep the top 16 bits.
        send_slot(1'b0, 25, {8'b0, 24'h123456}, -1);
        send_slot(1'b1, 25, {8'b0, 24'hFEDCBA}, -1);
        wait_clks(8);
        check("long_left", {16'b0, audio_left}, 32'h0000_1234);
        check("long_right", {16'b0, audio_right}, 32'h0000_FEDC);
        check("long_err", 32'(n_err), 32'd1);
        check("long_count", 32'(n_valid), 32'd4);

        // Reset pulse halfway through a right slot.
        send_slot(1'b0, DW + 1, {16'b0, 16'hABCD}, -1);
        send_slot(1'b1, DW + 1, {16'b0, 16'h4321}, 8);
        check("rst_no_valid", 32'(n_valid), 32'd4);
        check("rst_locked", {31'b0, locked}, 32'd0);
        send_frame(16'h5555, 16'hAAAA);
        wait_clks(8);
        check("rst_recover_l", {16'b0, audio_left}, 32'h0000_5555);
        check("rst_recover_r", {16'b0, audio_right}, 32'h0000_AAAA);
        check("rst_recover_locked", {31'b0, locked}, 32'd1);
        check("rst_recover_count", 32'(n_valid), 32'd5);

        // Minimum-rate stress: sck = clk/4 with random words.
        half = 2;
        for (int f = 0; f < 400; f++) begin
            l = 16'($urandom);
            r = 16'($urandom);
            send_frame(l, r);
        end
        wait_clks(8);
        check("stress_err", 32'(n_err), 32'd1);
        check("total_err", 32'(n_err), 32'(exp_err));
        check("total_valid", 32'(n_valid), 32'(exp_valid));
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
